// File: rtl/div_pkg.sv
// Shared definitions for seq_divider: FSM state encoding and counter sizing.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate (neg ? -x : x); only built with SIGNED_DIV_EN.
`ifdef SIGNED_DIV_EN
module div_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_y = i_neg ? (~i_x + ONE) : i_x;

endmodule
`endif

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Optional signed (truncating) division is enabled by defining SIGNED_DIV_EN.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       o_state
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SIGNED_DIV_EN
    localparam bit HAS_FIX = 1'b1;
`else
    localparam bit HAS_FIX = 1'b0;
`endif

    // Handshake: start is taken only in IDLE (busy=0, done=0); busy stays high
    // until the single-cycle done pulse, during which busy is already low.
    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_count;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_r;
    logic [WIDTH-1:0]  r_dvs;
    logic [WIDTH-1:0]  r_dvd_raw;
    logic              r_dbz_op;
    logic [WIDTH-1:0]  r_quot;
    logic [WIDTH-1:0]  r_rem;
    logic              r_dbz_out;

    logic              w_accept;
    logic [WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;
    logic [WIDTH-1:0]  w_r_shift;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_r_next;
    logic [WIDTH-1:0]  w_q_next;

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef SIGNED_DIV_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    div_abs #(.WIDTH(WIDTH)) u_abs_dvd (
        .i_x(dividend), .i_neg(is_signed & dividend[WIDTH-1]), .o_y(w_dvd_mag));
    div_abs #(.WIDTH(WIDTH)) u_abs_dvs (
        .i_x(divisor), .i_neg(is_signed & divisor[WIDTH-1]), .o_y(w_dvs_mag));
    div_abs #(.WIDTH(WIDTH)) u_fix_q (
        .i_x(r_q), .i_neg(r_neg_q), .o_y(w_q_fix));
    div_abs #(.WIDTH(WIDTH)) u_fix_r (
        .i_x(r_r), .i_neg(r_neg_r), .o_y(w_r_fix));

    // Remainder takes the dividend's sign, giving truncating division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= is_signed & dividend[WIDTH-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    assign w_r_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_diff    = {1'b0, w_r_shift} - {1'b0, r_dvs};
    assign w_r_next  = w_diff[WIDTH] ? w_r_shift : w_diff[WIDTH-1:0];
    assign w_q_next  = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_RUN;
            S_RUN: begin
                if (r_count == '0) begin
                    w_next_state = (r_dbz_op || !HAS_FIX) ? S_DONE : S_FIX;
                end
            end
            S_FIX:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == S_RUN) || (r_state == S_FIX);
        done    = (r_state == S_DONE);
        o_state = r_state;
    end

    // A zero divisor runs a single RUN cycle with count preloaded to 0, so its
    // results land two edges after accept instead of WIDTH+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_dbz_op  <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz_out <= 1'b0;
        end else if (w_accept) begin
            r_q       <= w_dvd_mag;
            r_r       <= '0;
            r_dvs     <= w_dvs_mag;
            r_dvd_raw <= dividend;
            r_dbz_op  <= (divisor == '0);
            r_count   <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
            r_dbz_out <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (r_count != '0) begin
                r_count <= r_count - CW'(1);
            end else if (r_dbz_op) begin
                r_quot    <= '1;
                r_rem     <= r_dvd_raw;
                r_dbz_out <= 1'b1;
            end else if (!HAS_FIX) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
            end
        end
`ifdef SIGNED_DIV_EN
        else if (r_state == S_FIX) begin
            r_quot <= w_q_fix;
            r_rem  <= w_r_fix;
        end
`endif
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with an arithmetic reference model and scoreboard.
module tb_seq_divider;

    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam int RUN_LAT = W + 2;
`else
    localparam int RUN_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef SIGNED_DIV_EN
    logic         is_signed = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int pcount = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic         exp_dbz_q[$];
    int           exp_lat_q[$];
    int           acc_q[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    logic [W-1:0] tv_a[4] = '{32'd0, 32'd1, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [W-1:0] tv_b[4] = '{32'd1, 32'hFFFF_FFFF, 32'd3, 32'h0000_1234};

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
`ifdef SIGNED_DIV_EN
        .is_signed(is_signed),
`endif
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .o_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) pcount <= pcount + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic, truncating signed division.
    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sgn, output logic [W-1:0] q,
                                      output logic [W-1:0] r, output logic z);
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = W'($signed(a) / $signed(b));
                r = W'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Driver: wait for idle, present one start, push the model prediction.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           waited = 0;
        while ((busy || done) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (busy || done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_wait: got busy expected idle within 100 cycles");
        end
        model_div(a, b, sgn, q, r, z);
        exp_q.push_back(q);
        exp_rem_q.push_back(r);
        exp_dbz_q.push_back(z);
        exp_lat_q.push_back(z ? 2 : RUN_LAT);
        acc_q.push_back(pcount + 1);
        dividend = a;
        divisor = b;
`ifdef SIGNED_DIV_EN
        is_signed = sgn;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy || done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic check_held(input string name, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic z);
        check({name, "_quot"}, quotient, q);
        check({name, "_rem"}, remainder, r);
        check({name, "_dbz"}, div_by_zero, z);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_quot"}, quotient, 0);
        check({name, "_rem"}, remainder, 0);
        check({name, "_dbz"}, div_by_zero, 0);
        check({name, "_state"}, dbg_state, 0);
    endtask

    // Scoreboard compare, every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_rem_q.delete();
            exp_dbz_q.delete();
            exp_lat_q.delete();
            acc_q.delete();
            last_q = '0;
            last_r = '0;
            last_z = 1'b0;
        end else begin
            check("busy_done_excl", busy & done, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    last_q = exp_q.pop_front();
                    last_r = exp_rem_q.pop_front();
                    last_z = exp_dbz_q.pop_front();
                    check("sb_quot", quotient, last_q);
                    check("sb_rem", remainder, last_r);
                    check("sb_dbz", div_by_zero, last_z);
                    check("sb_latency", W'(pcount - acc_q.pop_front() + 1), W'(exp_lat_q.pop_front()));
                end
            end else if (!busy) begin
                check("hold_quot", quotient, last_q);
                check("hold_rem", remainder, last_r);
                check("hold_dbz", div_by_zero, last_z);
            end
        end
    end

    // Stimulus
    initial begin
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mz;
        int           k;

        model_div(32'd100, 32'd7, 1'b0, mq, mr, mz);
        check("pin_100_7_q", mq, 32'd14);
        check("pin_100_7_r", mr, 32'd2);
        model_div(32'd1234, 32'd0, 1'b0, mq, mr, mz);
        check("pin_dbz_q", mq, 32'hFFFF_FFFF);
        check("pin_dbz_r", mr, 32'd1234);
        check("pin_dbz_z", mz, 1);
        model_div(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, mz);
        check("pin_m7_2_q", mq, 32'hFFFF_FFFD);
        check("pin_m7_2_r", mr, 32'hFFFF_FFFF);
        model_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mz);
        check("pin_ovf_q", mq, 32'h8000_0000);
        check("pin_ovf_r", mr, 32'd0);

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0);
        drain();
        check_held("t1_100_7", 32'd14, 32'd2, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        drain();
        check_held("t2_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_div(32'd5, 32'd9, 1'b0);
        drain();
        check_held("t2_5_9", 32'd0, 32'd5, 1'b0);
        do_div(32'd1234, 32'd0, 1'b0);
        drain();
        check_held("t3_dbz", 32'hFFFF_FFFF, 32'd1234, 1'b1);

        for (int i = 0; i < 4; i++) begin
            do_div(tv_a[i], tv_b[i], 1'b0);
            drain();
        end

        // Starts during RUN and during done must be ignored.
        do_div(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        check("t4_dbz_cleared", div_by_zero, 0);
        repeat (20) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor = W'($urandom_range(0, 5));
        end
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_done_seen", done, 1);
        start = 1'b1;
        dividend = 32'd9;
        divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        do_div(32'd50, 32'd7, 1'b0);
        drain();
        check_held("t4_back_to_back", 32'd7, 32'd1, 1'b0);

        // Asynchronous reset in the middle of RUN.
        do_div(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5_async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(32'd50, 32'd5, 1'b0);
        drain();
        check_held("t5_50_5", 32'd10, 32'd0, 1'b0);

`ifdef SIGNED_DIV_EN
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        drain();
        check_held("t6_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();
        check_held("t6_ovf", 32'h8000_0000, 32'd0, 1'b0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
        drain();
        check_held("t6_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1);
        drain();
        check_held("t6_sdbz", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
